seg7_scan: RTL and testbench

Memory-mapped driver for a 4-digit multiplexed seven-segment display on the CPU memory bus. Each digit comes either from a CPU-written data register or directly from the rtc block's BCD MM:SS value. The block time-multiplexes the digits with an anti-ghosting blank gap, decodes each nibble to segments, and applies a decimal-point mask and leading-zero blanking.

---
 rtl/seg7_scan_if.sv | 27 ++
 rtl/seg7_scan.sv | 176 +++++++++++++++++
 tb/tb_seg7_scan.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_if.sv
// Memory-bus port bundle for the seg7_scan peripheral.
// The master drives address/select/write signals; the slave (seg7_scan)
// returns combinational read data and ready.
//   address_in      32  bus address (only bit 2 decoded by the slave)
//   sel_in           1  peripheral select
//   read_value_out  32  read data, 0 when not selected
//   write_mask_in    4  byte-lane write enables
//   write_value_in  32  write data
//   ready_out        1  mirrors sel_in
interface seg7_scan_if;
    logic [31:0] address_in;
    logic        sel_in;
    logic [31:0] read_value_out;
    logic [3:0]  write_mask_in;
    logic [31:0] write_value_in;
    logic        ready_out;

    modport master (
        output address_in, sel_in, write_mask_in, write_value_in,
        input  read_value_out, ready_out
    );

    modport slave (
        input  address_in, sel_in, write_mask_in, write_value_in,
        output read_value_out, ready_out
    );
endinterface

// File: rtl/seg7_scan.sv
// Four-digit multiplexed seven-segment display driver on the memory bus.
// Digits come from the DATA register or from the rtc BCD time; each digit
// is driven for SCAN_COUNT cycles, separated by BLANK_COUNT all-off cycles.
//   clk_in     clock
//   reset      synchronous, active-high
//   bus        memory bus slave (DATA at bit2=0, CTRL at bit2=1)
//   time_in    BCD {minHi,minLo,secHi,secLo}
//   seg_out    active-high segments, bit0=a .. bit6=g (registered)
//   dp_out     active-high decimal point (registered)
//   an_out     active-high one-hot digit enable, bit0 rightmost (registered)
module seg7_scan #(
    parameter int unsigned SCAN_COUNT  = 50000,
    parameter int unsigned BLANK_COUNT = 16
) (
    input  logic              clk_in,
    input  logic              reset,
    seg7_scan_if.slave        bus,
    input  logic [15:0]       time_in,
    output logic [6:0]        seg_out,
    output logic              dp_out,
    output logic [3:0]        an_out
);
    localparam int unsigned MAX_COUNT = (SCAN_COUNT > BLANK_COUNT) ? SCAN_COUNT : BLANK_COUNT;
    localparam int unsigned CNT_W     = $clog2(MAX_COUNT + 1);

    typedef enum logic {ST_BLANK, ST_DRIVE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         idx_q, idx_d;
    logic [15:0]        data_q, data_d;
    logic [8:0]         ctrl_q, ctrl_d;
    logic [3:0]         an_q, an_d;
    logic [6:0]         seg_q, seg_d;
    logic               dp_q, dp_d;

    logic               wr_en;
    logic [15:0]        src;
    logic [3:0]         blank;
    logic [3:0]         nib;
    logic [6:0]         cur_seg;
    logic               cur_dp;
    logic               unused_bits;

    assign unused_bits = ^{bus.address_in[31:3], bus.address_in[1:0], bus.write_value_in[31:16]};

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: glyph = 7'h3F;
            4'h1: glyph = 7'h06;
            4'h2: glyph = 7'h5B;
            4'h3: glyph = 7'h4F;
            4'h4: glyph = 7'h66;
            4'h5: glyph = 7'h6D;
            4'h6: glyph = 7'h7D;
            4'h7: glyph = 7'h07;
            4'h8: glyph = 7'h7F;
            4'h9: glyph = 7'h6F;
            4'hA: glyph = 7'h77;
            4'hB: glyph = 7'h7C;
            4'hC: glyph = 7'h39;
            4'hD: glyph = 7'h5E;
            4'hE: glyph = 7'h79;
            default: glyph = 7'h71;
        endcase
    endfunction

    // Bus side: combinational read, byte-lane writes
    assign bus.ready_out      = bus.sel_in;
    assign bus.read_value_out = !bus.sel_in     ? '0 :
                                bus.address_in[2] ? {23'd0, ctrl_q} : {16'd0, data_q};
    assign wr_en = bus.sel_in && (|bus.write_mask_in);

    always_comb begin
        data_d = data_q;
        ctrl_d = ctrl_q;
        if (wr_en && !bus.address_in[2]) begin
            if (bus.write_mask_in[0]) data_d[7:0]  = bus.write_value_in[7:0];
            if (bus.write_mask_in[1]) data_d[15:8] = bus.write_value_in[15:8];
        end
        if (wr_en && bus.address_in[2]) begin
            if (bus.write_mask_in[0]) ctrl_d[7:0] = bus.write_value_in[7:0];
            if (bus.write_mask_in[1]) ctrl_d[8]   = bus.write_value_in[8];
        end
    end

    // Digit source, leading-zero chain and decode of the current digit
    assign src = ctrl_q[1] ? time_in : data_q;

    always_comb begin
        blank    = '0;
        blank[3] = ctrl_q[8] && (src[15:12] == 4'h0);
        blank[2] = blank[3]  && (src[11:8]  == 4'h0);
        blank[1] = blank[2]  && (src[7:4]   == 4'h0);
        case (idx_q)
            2'd0:    nib = src[3:0];
            2'd1:    nib = src[7:4];
            2'd2:    nib = src[11:8];
            default: nib = src[15:12];
        endcase
        cur_seg = blank[idx_q] ? 7'h00 : glyph(nib);
        cur_dp  = ctrl_q[4 + {30'd0, idx_q}];
    end

    // Scan FSM
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        an_d    = an_q;
        seg_d   = seg_q;
        dp_d    = dp_q;
        if (!ctrl_q[0]) begin
            state_d = ST_BLANK;
            cnt_d   = '0;
            idx_d   = '0;
            an_d    = '0;
            seg_d   = '0;
            dp_d    = 1'b0;
        end else begin
            case (state_q)
                ST_BLANK: begin
                    if (cnt_q == CNT_W'(BLANK_COUNT - 1)) begin
                        state_d = ST_DRIVE;
                        cnt_d   = '0;
                        an_d    = 4'b0001 << idx_q;
                        seg_d   = cur_seg;
                        dp_d    = cur_dp;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    if (cnt_q == CNT_W'(SCAN_COUNT - 1)) begin
                        state_d = ST_BLANK;
                        cnt_d   = '0;
                        an_d    = '0;
                        seg_d   = '0;
                        dp_d    = 1'b0;
                        idx_d   = idx_q + 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                        seg_d = cur_seg;
                        dp_d  = cur_dp;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q <= ST_BLANK;
            cnt_q   <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            ctrl_q  <= '0;
            an_q    <= '0;
            seg_q   <= '0;
            dp_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            ctrl_q  <= ctrl_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
        end
    end

    assign an_out  = an_q;
    assign seg_out = seg_q;
    assign dp_out  = dp_q;
endmodule

// File: tb/tb_seg7_scan.sv
// Directed self-checking bench for seg7_scan with SCAN_COUNT=4, BLANK_COUNT=2.
module tb_seg7_scan;
    localparam int unsigned S = 4;
    localparam int unsigned B = 2;

    logic        clk;
    logic        reset;
    logic [15:0] time_in;
    logic [6:0]  seg_out;
    logic        dp_out;
    logic [3:0]  an_out;

    int unsigned checks;
    int unsigned failures;

    seg7_scan_if bus ();

    seg7_scan #(.SCAN_COUNT(S), .BLANK_COUNT(B)) dut (
        .clk_in  (clk),
        .reset   (reset),
        .bus     (bus),
        .time_in (time_in),
        .seg_out (seg_out),
        .dp_out  (dp_out),
        .an_out  (an_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] val, input logic [3:0] mask);
        @(negedge clk);
        bus.address_in     = addr;
        bus.write_value_in = val;
        bus.write_mask_in  = mask;
        bus.sel_in         = 1'b1;
        @(posedge clk);
        #1;
        bus.sel_in        = 1'b0;
        bus.write_mask_in = 4'b0000;
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] val, output logic rdy);
        @(negedge clk);
        bus.address_in    = addr;
        bus.write_mask_in = 4'b0000;
        bus.sel_in        = 1'b1;
        #1;
        val = bus.read_value_out;
        rdy = bus.ready_out;
        bus.sel_in = 1'b0;
    endtask

    function automatic logic [31:0] disp(input logic [3:0] an, input logic dp, input logic [6:0] seg);
        disp = {20'd0, an, dp, seg};
    endfunction

    // Positioned just after the edge that starts a digit's DRIVE; checks
    // the whole drive window and the following gap, ends at the next digit.
    task automatic check_digit(input string tag, input logic [3:0] an, input logic [6:0] seg, input logic dp);
        for (int i = 0; i < int'(S); i++) begin
            chk(tag, disp(an_out, dp_out, seg_out), disp(an, dp, seg));
            step();
        end
        for (int i = 0; i < int'(B); i++) begin
            chk({tag, "_gap"}, disp(an_out, dp_out, seg_out), 32'd0);
            step();
        end
    endtask

    // Restart the scan from a disabled state; ends at the start of digit 0.
    task automatic start_scan(input logic [31:0] ctrl);
        bus_write(32'h4, 32'h0, 4'b0011);
        bus_write(32'h4, ctrl, 4'b0011);
        for (int i = 0; i < int'(B); i++) begin
            chk("en_latency", {28'd0, an_out}, 32'd0);
            step();
        end
    endtask

    logic [31:0] rv;
    logic        rr;

    initial begin
        checks   = 0;
        failures = 0;
        time_in  = 16'h5909;
        bus.address_in     = '0;
        bus.write_value_in = '0;
        bus.write_mask_in  = '0;
        bus.sel_in         = 1'b0;
        reset              = 1'b1;

        // Reset with random bus traffic
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            bus.address_in     = $urandom;
            bus.write_value_in = $urandom;
            bus.write_mask_in  = 4'($urandom_range(1, 15));
            bus.sel_in         = 1'b1;
        end
        @(negedge clk);
        bus.sel_in = 1'b0;
        reset      = 1'b0;
        chk("rst_disp", disp(an_out, dp_out, seg_out), 32'd0);
        bus_read(32'h4, rv, rr);
        chk("rst_ctrl", rv, 32'd0);
        chk("rst_ready", {31'd0, rr}, 32'd1);
        bus_read(32'h0, rv, rr);
        chk("rst_data", rv, 32'd0);
        #1;
        chk("nosel_read", {bus.read_value_out[30:0], bus.ready_out}, 32'd0);

        // Scan order
        bus_write(32'h0, 32'h0000_1234, 4'b0011);
        start_scan(32'h001);
        check_digit("scan_d0", 4'b0001, 7'h66, 1'b0);
        check_digit("scan_d1", 4'b0010, 7'h4F, 1'b0);
        check_digit("scan_d2", 4'b0100, 7'h5B, 1'b0);
        check_digit("scan_d3", 4'b1000, 7'h06, 1'b0);
        check_digit("scan_rep", 4'b0001, 7'h66, 1'b0);

        // Leading-zero blanking
        bus_write(32'h0, 32'h0000_0070, 4'b0011);
        start_scan(32'h101);
        check_digit("lzb_d0", 4'b0001, 7'h3F, 1'b0);
        check_digit("lzb_d1", 4'b0010, 7'h07, 1'b0);
        check_digit("lzb_d2", 4'b0100, 7'h00, 1'b0);
        check_digit("lzb_d3", 4'b1000, 7'h00, 1'b0);
        start_scan(32'h001);
        check_digit("nolzb_d0", 4'b0001, 7'h3F, 1'b0);
        check_digit("nolzb_d1", 4'b0010, 7'h07, 1'b0);
        check_digit("nolzb_d2", 4'b0100, 7'h3F, 1'b0);
        check_digit("nolzb_d3", 4'b1000, 7'h3F, 1'b0);

        // RTC source with dp on digit 2
        start_scan(32'h043);
        check_digit("rtc_d0", 4'b0001, 7'h6F, 1'b0);
        check_digit("rtc_d1", 4'b0010, 7'h3F, 1'b0);
        check_digit("rtc_d2", 4'b0100, 7'h6F, 1'b1);
        check_digit("rtc_d3", 4'b1000, 7'h6D, 1'b0);

        // Byte-mask writes
        bus_write(32'h0, 32'h0, 4'b1111);
        bus_write(32'h0, 32'hAABB_CCDD, 4'b0001);
        bus_write(32'h0, 32'hFFFF_EEFF, 4'b0010);
        bus_read(32'h0, rv, rr);
        chk("mask_data", rv, 32'h0000_EEDD);
        bus_write(32'h0, 32'h1234_5678, 4'b0000);
        bus_read(32'h0, rv, rr);
        chk("mask_none", rv, 32'h0000_EEDD);
        bus_write(32'h4, 32'hFFFF_FFFF, 4'b1111);
        bus_read(32'h4, rv, rr);
        chk("ctrl_width", rv, 32'h0000_01FF);

        // Disable in the 2nd cycle of digit 2, then re-enable
        bus_write(32'h0, 32'h0000_1234, 4'b0011);
        start_scan(32'h001);
        check_digit("dis_d0", 4'b0001, 7'h66, 1'b0);
        check_digit("dis_d1", 4'b0010, 7'h4F, 1'b0);
        chk("dis_d2_c1", disp(an_out, dp_out, seg_out), disp(4'b0100, 1'b0, 7'h5B));
        step();
        bus_write(32'h4, 32'h0, 4'b0011);
        chk("dis_edge", disp(an_out, dp_out, seg_out), disp(4'b0100, 1'b0, 7'h5B));
        step();
        chk("dis_off", disp(an_out, dp_out, seg_out), 32'd0);
        bus_write(32'h4, 32'h001, 4'b0001);
        for (int i = 0; i < int'(B); i++) begin
            chk("reen_gap", {28'd0, an_out}, 32'd0);
            step();
        end
        chk("reen_d0", disp(an_out, dp_out, seg_out), disp(4'b0001, 1'b0, 7'h66));

        // Reset mid-scan with a concurrent write
        step();
        @(negedge clk);
        reset              = 1'b1;
        bus.address_in     = 32'h0;
        bus.write_value_in = 32'hFFFF_FFFF;
        bus.write_mask_in  = 4'b1111;
        bus.sel_in         = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_disp", disp(an_out, dp_out, seg_out), 32'd0);
        @(negedge clk);
        reset      = 1'b0;
        bus.sel_in = 1'b0;
        bus_read(32'h0, rv, rr);
        chk("midrst_data", rv, 32'd0);
        bus_read(32'h4, rv, rr);
        chk("midrst_ctrl", rv, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
